// File: rtl/dmem_responder.sv
// Multi-cycle handshaked data-memory target for the core's load/store port.
// One request in flight; fixed wait states; misaligned/out-of-range flagged.
module dmem_responder #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [DWIDTH-1:0] cap_addr;
    logic [DWIDTH-1:0] cap_wdata;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic              accept;
    logic              access;
    logic              acc_we;
    logic              acc_err;
    logic [DWIDTH-1:0] acc_addr;
    logic [DWIDTH-1:0] acc_wdata;
    logic [AW-1:0]     acc_idx;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_ready && req_valid;

    // With no wait states the access uses the live request on its accept edge.
    assign access = (LATENCY == 0) ? accept
                                   : (state == WAIT && cnt == 4'd0);

    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];
    assign acc_err = (acc_addr[1:0] != 2'd0)
                  || ((acc_addr >> (AW + 2)) != '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req_valid) state_nx = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage is never cleared; reset only suppresses an uncommitted store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!acc_we && !acc_err) ? mem[acc_idx] : '0;
                if (acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
            end else if (rsp_valid && rsp_ready) begin
                rsp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: LATENCY=2 and LATENCY=0 instances
// checked against a word-array reference model.
module tb_dmem_responder;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    logic [31:0] mdl [2][256];
    int          lat [2] = '{2, 0};
    int          checks = 0;
    int          errors = 0;

    dmem_responder #(.DWIDTH(32), .DEPTH(256), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DWIDTH(32), .DEPTH(256), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) return $urandom;
        if (k == 1) return 32'($urandom_range(0, 1023)) | 32'd1;
        if (k == 2) return 32'(1024 + $urandom_range(0, 4095));
        return 32'($urandom_range(0, 255)) * 32'd4;
    endfunction

    task automatic garbage(input int d);
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input int bp);
        logic [31:0] ed;
        logic        ee;
        int          n;
        ee = bad_addr(addr);
        ed = '0;
        if (!ee && !we) ed = mdl[d][addr[9:2]];
        if (!ee && we) mdl[d][addr[9:2]] = wd;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        rsp_ready[d] = 1'($urandom);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        garbage(d);
        n = 0;
        while (!rsp_valid[d] && n < 20) begin
            chk("wait_ready", 32'(req_ready[d]), 32'd0);
            req_valid[d] = 1'($urandom);
            rsp_ready[d] = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat[d]));
        rsp_ready[d] = 1'b0;
        chk("rsp_err", 32'(rsp_err[d]), 32'(ee));
        chk("rsp_rdata", rsp_rdata[d], ed);
        chk("resp_ready", 32'(req_ready[d]), 32'd0);
        for (int i = 0; i < bp; i++) begin
            req_valid[d] = 1'($urandom);
            garbage(d);
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
            chk("bp_rdata", rsp_rdata[d], ed);
            chk("bp_err", 32'(rsp_err[d]), 32'(ee));
            chk("bp_ready", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        chk("done_valid", 32'(rsp_valid[d]), 32'd0);
        chk("done_err", 32'(rsp_err[d]), 32'd0);
        chk("done_rdata", rsp_rdata[d], ed);
        chk("done_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] old;
        logic [31:0] bw [3];
        logic [31:0] exp;
        rst       = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                txn(d, 1'b1, 32'(i * 4), $urandom, 0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 5);
        txn(0, 1'b0, 32'h13, 32'h0, 1);
        txn(0, 1'b1, 32'h400, 32'h12345678, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 0);

        // Store interrupted by reset one cycle after acceptance.
        old = mdl[0][8];
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("mid_rst_ready", 32'(req_ready[0]), 32'd1);
        chk("mid_rst_err", 32'(rsp_err[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, 0);
        chk("mid_rst_old", mdl[0][8], old);

        for (int i = 0; i < 80; i++)
            txn(0, 1'($urandom), rnd_addr(), $urandom, $urandom_range(0, 3));

        // Zero-latency instance with request and response held high.
        for (int i = 0; i < 3; i++) bw[i] = $urandom;
        @(negedge clk);
        rsp_ready[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid[1] = 1'b1;
            req_we[1]    = (k < 3);
            req_addr[1]  = 32'((k % 3) * 4);
            req_wdata[1] = bw[k % 3];
            exp = (k < 3) ? 32'h0 : bw[k - 3];
            if (k < 3) mdl[1][k] = bw[k];
            @(posedge clk); #1;
            chk("b2b_valid", 32'(rsp_valid[1]), 32'd1);
            chk("b2b_rdata", rsp_rdata[1], exp);
            chk("b2b_busy", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
            chk("b2b_idle_valid", 32'(rsp_valid[1]), 32'd0);
            chk("b2b_idle_ready", 32'(req_ready[1]), 32'd1);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;

        for (int i = 0; i < 40; i++)
            txn(1, 1'($urandom), rnd_addr(), $urandom, $urandom_range(0, 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
